echo_delay_ctrl: RTL and testbench

Sequencing controller for the echo-reduction delay-line FIFO. It owns the FIFO's reset, write and read enables. It primes the FIFO to a programmable delay, measured in samples, then holds occupancy constant so the read side always returns the sample written exactly `cfg_delay` samples earlier. It sits between the I2S sample strobe and the echo FIFO, and tells the subtract/saturate datapath when the delayed sample is valid.

---
 rtl/echo_ctrl_pkg.sv | 22 ++
 rtl/echo_delay_ctrl.sv | 120 ++++++++++++
 tb/tb_echo_delay_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/echo_ctrl_pkg.sv
// rtl/echo_ctrl_pkg.sv - shared state encoding and delay clamp helpers for the echo delay-line controller
package echo_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_PRIME = 2'd2,
        ST_RUN   = 2'd3
    } echo_state_t;

    localparam int unsigned DEFAULT_FIFO_DEPTH = 4096;
    localparam int unsigned DELAY_MIN          = 1;
    localparam int unsigned DELAY_MAX          = DEFAULT_FIFO_DEPTH - 1;

    // A zero delay cannot be primed, and the FIFO must keep one free slot.
    function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned max_d);
        if (d < DELAY_MIN) return DELAY_MIN;
        if (d > max_d)     return max_d;
        return d;
    endfunction

endpackage

// File: rtl/echo_delay_ctrl.sv
// rtl/echo_delay_ctrl.sv - primes the echo FIFO to a programmable delay and holds its occupancy constant
module echo_delay_ctrl
    import echo_ctrl_pkg::*;
#(
    parameter int DELAY_W      = 12,
    parameter int FIFO_DEPTH   = 4096,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic               sck,
    input  logic               rst,
    input  logic               enable,
    input  logic               sample_valid,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic               cfg_load,
    input  logic               fifo_full,
    input  logic               fifo_empty,
    output logic               fifo_rst,
    output logic               fifo_wr_en,
    output logic               fifo_rd_en,
    output logic               echo_valid,
    output logic [DELAY_W:0]   level,
    output logic               busy,
    output logic               err
);

    localparam int          CNT_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned DELAY_LIM = FIFO_DEPTH - 1;

    echo_state_t        state_q, state_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [DELAY_W:0]   level_q, level_d, level_inc;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic               err_q, err_d;
    logic               overflow, underflow;

    assign overflow  = (state_q == ST_PRIME) && sample_valid && fifo_full;
    assign underflow = (state_q == ST_RUN)   && sample_valid && fifo_empty;
    assign level_inc = level_q + 1'b1;

    // Enables follow the strobe combinationally so the write lands in the strobe cycle.
    assign fifo_rst   = (state_q == ST_FLUSH);
    assign busy       = (state_q == ST_FLUSH) || (state_q == ST_PRIME);
    assign echo_valid = (state_q == ST_RUN);
    assign fifo_wr_en = sample_valid && (((state_q == ST_PRIME) && !fifo_full) || (state_q == ST_RUN));
    assign fifo_rd_en = sample_valid && (state_q == ST_RUN) && !fifo_empty;
    assign level      = level_q;
    assign err        = err_q;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        level_d     = level_q;
        delay_d     = delay_q;
        err_d       = err_q;

        if (cfg_load) begin
            delay_d = DELAY_W'(clamp_delay(32'(cfg_delay), DELAY_LIM));
            err_d   = 1'b0;
        end

        if (!enable) begin
            state_d = ST_IDLE;
            level_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                    level_d     = '0;
                end
                ST_FLUSH: begin
                    level_d = '0;
                    if (flush_cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                        state_d = ST_PRIME;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
                ST_PRIME: begin
                    if (cfg_load || overflow) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = '0;
                        level_d     = '0;
                        if (!cfg_load) err_d = 1'b1;
                    end else if (sample_valid) begin
                        level_d = level_inc;
                        if (level_inc == {1'b0, delay_q}) state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Balanced read/write leaves level untouched here.
                    if (cfg_load || underflow) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = '0;
                        level_d     = '0;
                        if (!cfg_load) err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            level_q     <= '0;
            delay_q     <= DELAY_W'(DELAY_MIN);
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            level_q     <= level_d;
            delay_q     <= delay_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// tb/tb_echo_delay_ctrl.sv - self-checking bench for echo_delay_ctrl with a queue-based delay-line model
module tb_echo_delay_ctrl;

    localparam int DW    = 13;
    localparam int DEPTH = 4096;
    localparam int FLUSH = 4;

    logic          sck = 1'b0;
    logic          rst, enable, sample_valid, cfg_load, fifo_full, fifo_empty;
    logic [DW-1:0] cfg_delay;
    logic          fifo_rst, fifo_wr_en, fifo_rd_en, echo_valid, busy, err;
    logic [DW:0]   level;

    always #5 sck = ~sck;

    echo_delay_ctrl #(.DELAY_W(DW), .FIFO_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH)) dut (
        .sck(sck), .rst(rst), .enable(enable), .sample_valid(sample_valid),
        .cfg_delay(cfg_delay), .cfg_load(cfg_load), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_rst(fifo_rst), .fifo_wr_en(fifo_wr_en),
        .fifo_rd_en(fifo_rd_en), .echo_valid(echo_valid), .level(level),
        .busy(busy), .err(err)
    );

    int passed = 0, total = 0;
    int q[$];
    int cur_sample = 0, cyc = 0, exp_delay = 1;
    int rst_cycles, wr_cnt, rd_cnt, wr_in_flush, last_wr_cyc;
    bit force_empty = 0, saw_rd_en;

    function automatic int exp_clamp(input int d);
        if (d < 1) return 1;
        if (d > DEPTH - 1) return DEPTH - 1;
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock: present the FIFO flags from the model, observe outputs mid-cycle, advance.
    task automatic clk_cycle();
        int v;
        if (sample_valid) cur_sample++;
        fifo_empty = force_empty || (q.size() == 0);
        fifo_full  = (q.size() >= DEPTH);
        #1;
        saw_rd_en = fifo_rd_en;
        if (fifo_rst) begin
            rst_cycles++;
            q.delete();
            if (fifo_wr_en) wr_in_flush++;
        end
        if (fifo_rd_en) begin
            v = (q.size() > 0) ? q.pop_front() : -1;
            rd_cnt++;
            check("rd_data", v, cur_sample - exp_delay);
        end
        if (fifo_wr_en) begin
            q.push_back(cur_sample);
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        @(posedge sck);
        @(negedge sck);
        cyc++;
        sample_valid = 1'b0;
        cfg_load     = 1'b0;
    endtask

    task automatic run_prime(input int d, input int min_gap, input int max_gap);
        int budget, wait_n;
        rst_cycles = 0; wr_cnt = 0; rd_cnt = 0; wr_in_flush = 0; last_wr_cyc = -10;
        exp_delay = d; budget = 0; wait_n = 0;
        while (!echo_valid && budget < 20000) begin
            if (wait_n == 0) begin
                sample_valid = 1'b1;
                wait_n = $urandom_range(min_gap, max_gap) - 1;
            end else begin
                wait_n--;
            end
            clk_cycle();
            budget++;
        end
        check("prime_timeout", echo_valid, 1'b1);
        check("flush_len", rst_cycles, FLUSH);
        check("prime_writes", wr_cnt, d);
        check("prime_reads", rd_cnt, 0);
        check("flush_ignored", wr_in_flush, 0);
        check("run_entry", cyc, last_wr_cyc + 1);
        check("run_level", level, d);
    endtask

    task automatic run_run(input int n, input int min_gap, input int max_gap);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(min_gap, max_gap) - 1) clk_cycle();
            sample_valid = 1'b1;
            clk_cycle();
            check("run_hold", {echo_valid, 18'(level)}, {1'b1, 18'(exp_delay)});
        end
        check("run_reads", rd_cnt, n);
    endtask

    task automatic load(input int d);
        cfg_delay = DW'(d);
        cfg_load  = 1'b1;
        clk_cycle();
    endtask

    initial begin
        int n, d;
        rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; cfg_load = 1'b0;
        cfg_delay = '0; fifo_full = 1'b0; fifo_empty = 1'b1;
        repeat (3) clk_cycle();
        check("reset_outs", {fifo_rst, fifo_wr_en, fifo_rd_en, echo_valid, busy, err}, 6'b0);
        check("reset_level", level, 0);
        rst = 1'b0;

        // Reset delay of 1 primes after a single write.
        enable = 1'b1;
        run_prime(1, 1, 3);
        run_run(5, 1, 3);
        enable = 1'b0;
        clk_cycle();
        check("disable_outs", {fifo_rst, fifo_wr_en, fifo_rd_en, echo_valid, busy, err}, 6'b0);

        // Basic priming, delay 8, strobe every 4 cycles.
        load(8);
        enable = 1'b1;
        run_prime(8, 4, 4);
        run_run(10, 4, 4);

        // Reconfigure in RUN.
        load(3);
        check("reconf_flush", {fifo_rst, echo_valid}, 2'b10);
        run_prime(3, 1, 3);
        run_run(6, 1, 3);

        for (int k = 0; k < 4; k++) begin
            d = $urandom_range(1, 40);
            load(d);
            run_prime(d, 1, 3);
            run_run($urandom_range(3, 8), 1, 4);
        end

        // Zero delay clamps to one.
        load(0);
        run_prime(exp_clamp(0), 1, 2);
        run_run(3, 1, 2);

        // Underflow in RUN.
        force_empty  = 1'b1;
        sample_valid = 1'b1;
        clk_cycle();
        force_empty = 1'b0;
        check("uf_rd_en", saw_rd_en, 1'b0);
        check("uf_err_flush", {err, fifo_rst}, 2'b11);
        run_prime(1, 1, 2);
        check("uf_err_sticky", err, 1'b1);
        load(5);
        check("uf_err_clear", err, 1'b0);
        run_prime(5, 1, 2);
        run_run(4, 1, 2);

        // Disable mid-PRIME after two of eight writes.
        load(8);
        wr_cnt = 0; n = 0;
        while (wr_cnt < 2 && n < 200) begin
            sample_valid = (n % 3 == 0);
            clk_cycle();
            n++;
        end
        check("dis_writes", wr_cnt, 2);
        enable = 1'b0;
        clk_cycle();
        check("dis_idle_outs", {fifo_rst, fifo_wr_en, fifo_rd_en, echo_valid, busy, err}, 6'b0);
        check("dis_idle_level", level, 0);
        enable = 1'b1;
        run_prime(8, 1, 3);
        run_run(4, 1, 3);

        // Upper clamp.
        load(4095);
        run_prime(exp_clamp(4095), 1, 1);
        run_run(3, 1, 1);
        load(5000);
        run_prime(exp_clamp(5000), 1, 1);
        run_run(3, 1, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
